gb_cmd_sequencer: RTL and testbench

//  - Sole driver of the gb_memory instruction/position port.
//  - Latches move/spawn/clear requests from game logic and grants one at a time
//    by fixed priority.
//  - Tracks the falling piece position and issues the instruction.
//  - Then runs a full GET_ROW scan so the row_status consumer sees the updated board.

---
 rtl/gb_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_gb_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cmd_sequencer.sv
// gb_cmd_sequencer: sole driver of the gb_memory instruction/position port.
// Latches move/spawn/remove requests, grants one at a time by fixed priority
// (new > rm > down > left > right), issues the instruction while tracking the
// falling piece, then scans every row with GET_ROW so row_status refreshes.
// Optional feature macro: GB_SEQ_AUTO_CLEAR_EN -- after a DOWN sequence, a
// non-zero line_status queues a REMOVE of the lowest full row.
module gb_cmd_sequencer #(
    parameter int ROWS     = 20,
    parameter int HOLD_CYC = 4,
    parameter int X_MAX    = 8,
    parameter int SPAWN_X  = 5,
    parameter int SPAWN_Y  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_new,
    input  logic [1:0]  shape_sel,
    input  logic        req_rm,
    input  logic [15:0] rm_sel,
    input  logic        req_down,
    input  logic        req_left,
    input  logic        req_right,
    input  logic [31:0] line_status,
    output logic [5:0]  instr_op,
    output logic [15:0] rm_line_num,
    output logic [4:0]  x_pos,
    output logic [4:0]  y_pos,
    output logic [1:0]  shape,
    output logic [4:0]  get_line_num,
    output logic        busy,
    output logic        done,
    output logic        reject
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [5:0] OP_IDLE    = 6'h00;
    localparam logic [5:0] OP_NEW     = 6'h19;
    localparam logic [5:0] OP_LEFT    = 6'h1A;
    localparam logic [5:0] OP_RIGHT   = 6'h1B;
    localparam logic [5:0] OP_DOWN    = 6'h1C;
    localparam logic [5:0] OP_REMOVE  = 6'h1D;
    localparam logic [5:0] OP_GET_ROW = 6'h1F;

    // Pending-vector bit positions, highest index = highest priority.
    localparam int P_NEW   = 4;
    localparam int P_RM    = 3;
    localparam int P_DOWN  = 2;
    localparam int P_LEFT  = 1;
    localparam int P_RIGHT = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      pend_q, pend_d;
    logic [1:0]      shape_sel_q, shape_sel_d;
    logic [15:0]     rm_sel_q, rm_sel_d;
    logic            last_down_q, last_down_d;
    logic [4:0]      row_q, row_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [5:0]      instr_op_q, instr_op_d;
    logic [15:0]     rm_line_num_q, rm_line_num_d;
    logic [4:0]      x_q, x_d;
    logic [4:0]      y_q, y_d;
    logic [1:0]      shape_q, shape_d;
    logic [4:0]      gln_q, gln_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            reject_q, reject_d;

    logic [4:0]      grant_s;
    logic [5:0]      op_s;
    logic            legal_s;
    logic [4:0]      pend_clr_s;
    logic            auto_set_s;
    logic [4:0]      auto_idx_s;

`ifdef GB_SEQ_AUTO_CLEAR_EN
    // Index of the lowest set bit; caller guarantees v is non-zero.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Queue a REMOVE of the lowest full row when a DOWN sequence finishes.
    always_comb begin
        auto_set_s = 1'b0;
        auto_idx_s = 5'd0;
        if ((state_q == S_DONE) && last_down_q && (line_status != 32'h0000_0000)) begin
            auto_set_s = 1'b1;
            auto_idx_s = lowest_set(line_status);
        end else begin
            auto_set_s = 1'b0;
            auto_idx_s = 5'd0;
        end
    end
`else
    // Auto-clear disabled: board status is ignored entirely.
    logic unused_auto_s;
    assign unused_auto_s = ^{line_status, last_down_q};
    assign auto_set_s    = 1'b0;
    assign auto_idx_s    = 5'd0;
`endif

    // Fixed-priority pick among pending requests.
    always_comb begin
        grant_s = 5'b00000;
        op_s    = OP_IDLE;
        if (pend_q[P_NEW]) begin
            grant_s[P_NEW] = 1'b1;
            op_s           = OP_NEW;
        end else if (pend_q[P_RM]) begin
            grant_s[P_RM] = 1'b1;
            op_s          = OP_REMOVE;
        end else if (pend_q[P_DOWN]) begin
            grant_s[P_DOWN] = 1'b1;
            op_s            = OP_DOWN;
        end else if (pend_q[P_LEFT]) begin
            grant_s[P_LEFT] = 1'b1;
            op_s            = OP_LEFT;
        end else if (pend_q[P_RIGHT]) begin
            grant_s[P_RIGHT] = 1'b1;
            op_s             = OP_RIGHT;
        end else begin
            grant_s = 5'b00000;
            op_s    = OP_IDLE;
        end
    end

    // Moves that would leave the board are dropped; this also rules out wrap.
    always_comb begin
        if (grant_s[P_DOWN] && (y_q == 5'd0)) begin
            legal_s = 1'b0;
        end else if (grant_s[P_LEFT] && (x_q == 5'd0)) begin
            legal_s = 1'b0;
        end else if (grant_s[P_RIGHT] && (x_q == 5'(X_MAX))) begin
            legal_s = 1'b0;
        end else begin
            legal_s = 1'b1;
        end
    end

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        pend_clr_s    = 5'b00000;
        last_down_d   = last_down_q;
        row_d         = row_q;
        hold_d        = hold_q;
        instr_op_d    = instr_op_q;
        rm_line_num_d = rm_line_num_q;
        x_d           = x_q;
        y_d           = y_q;
        shape_d       = shape_q;
        gln_d         = gln_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        reject_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_op_d = OP_IDLE;
                busy_d     = 1'b0;
                gln_d      = 5'h1F;
                if (|pend_q) begin
                    pend_clr_s = grant_s;
                    if (legal_s) begin
                        state_d     = S_ISSUE;
                        instr_op_d  = op_s;
                        busy_d      = 1'b1;
                        last_down_d = grant_s[P_DOWN];
                        case (op_s)
                            OP_NEW: begin
                                x_d     = 5'(SPAWN_X);
                                y_d     = 5'(SPAWN_Y);
                                shape_d = shape_sel_q;
                            end
                            OP_LEFT:   x_d = x_q - 5'd1;
                            OP_RIGHT:  x_d = x_q + 5'd1;
                            OP_DOWN:   y_d = y_q - 5'd1;
                            OP_REMOVE: rm_line_num_d = rm_sel_q;
                            default:   x_d = x_q;
                        endcase
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    pend_clr_s = 5'b00000;
                end
            end
            S_ISSUE: begin
                state_d    = S_SCAN;
                instr_op_d = OP_GET_ROW;
                gln_d      = 5'd0;
                row_d      = 5'd0;
                hold_d     = '0;
            end
            S_SCAN: begin
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    hold_d = '0;
                    if (row_q == 5'(ROWS - 1)) begin
                        state_d    = S_DONE;
                        instr_op_d = OP_IDLE;
                        gln_d      = 5'h1F;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        row_d = row_q + 5'd1;
                        gln_d = row_q + 5'd1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh request wins over a grant clearing the same bit.
        pend_d = (pend_q & ~pend_clr_s)
               | {req_new, req_rm | auto_set_s, req_down, req_left, req_right};

        if (req_new) begin
            shape_sel_d = shape_sel;
        end else begin
            shape_sel_d = shape_sel_q;
        end

        if (req_rm) begin
            rm_sel_d = rm_sel;
        end else if (auto_set_s) begin
            rm_sel_d = {11'd0, auto_idx_s};
        end else begin
            rm_sel_d = rm_sel_q;
        end
    end

    // State, pending requests and all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pend_q        <= 5'b00000;
            shape_sel_q   <= 2'b00;
            rm_sel_q      <= 16'h0000;
            last_down_q   <= 1'b0;
            row_q         <= 5'd0;
            hold_q        <= '0;
            instr_op_q    <= OP_IDLE;
            rm_line_num_q <= 16'h0000;
            x_q           <= 5'd0;
            y_q           <= 5'd0;
            shape_q       <= 2'b00;
            gln_q         <= 5'h1F;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            shape_sel_q   <= shape_sel_d;
            rm_sel_q      <= rm_sel_d;
            last_down_q   <= last_down_d;
            row_q         <= row_d;
            hold_q        <= hold_d;
            instr_op_q    <= instr_op_d;
            rm_line_num_q <= rm_line_num_d;
            x_q           <= x_d;
            y_q           <= y_d;
            shape_q       <= shape_d;
            gln_q         <= gln_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            reject_q      <= reject_d;
        end
    end

    assign instr_op     = instr_op_q;
    assign rm_line_num  = rm_line_num_q;
    assign x_pos        = x_q;
    assign y_pos        = y_q;
    assign shape        = shape_q;
    assign get_line_num = gln_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign reject       = reject_q;

endmodule

// File: tb/tb_gb_cmd_sequencer.sv
// Testbench for gb_cmd_sequencer: directed steps plus randomized single
// requests, checked against a transaction-level model of piece position,
// legality and instruction sequencing.
module tb_gb_cmd_sequencer;

    localparam int ROWS = 20;
    localparam int HOLD = 4;
    localparam int XMAX = 8;
    localparam int SPX  = 5;
    localparam int SPY  = 16;
    localparam int LAT  = ROWS * HOLD + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_new, req_rm, req_down, req_left, req_right;
    logic [1:0]  shape_sel;
    logic [15:0] rm_sel;
    logic [31:0] line_status;
    logic [5:0]  instr_op;
    logic [15:0] rm_line_num;
    logic [4:0]  x_pos, y_pos, get_line_num;
    logic [1:0]  shape;
    logic        busy, done, reject;

    int n_cmp = 0;
    int n_bad = 0;
    int mx = 0;
    int my = 0;
    int mshape = 0;

    always #5 clk = ~clk;

    gb_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_new(req_new), .shape_sel(shape_sel),
        .req_rm(req_rm), .rm_sel(rm_sel), .req_down(req_down), .req_left(req_left),
        .req_right(req_right), .line_status(line_status), .instr_op(instr_op),
        .rm_line_num(rm_line_num), .x_pos(x_pos), .y_pos(y_pos), .shape(shape),
        .get_line_num(get_line_num), .busy(busy), .done(done), .reject(reject)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k: 0 new, 1 rm, 2 down, 3 left, 4 right
    function automatic logic [5:0] op_of(input int k);
        case (k)
            0:       return 6'h19;
            1:       return 6'h1D;
            2:       return 6'h1C;
            3:       return 6'h1A;
            default: return 6'h1B;
        endcase
    endfunction

    function automatic bit legal(input int k);
        case (k)
            2:       return my > 0;
            3:       return mx > 0;
            4:       return mx < XMAX;
            default: return 1'b1;
        endcase
    endfunction

    task automatic pulse(input int k, input logic [15:0] opnd);
        case (k)
            0: begin req_new = 1'b1; shape_sel = opnd[1:0]; end
            1: begin req_rm = 1'b1; rm_sel = opnd; end
            2: req_down = 1'b1;
            3: req_left = 1'b1;
            default: req_right = 1'b1;
        endcase
        tick();
        req_new = 1'b0; req_rm = 1'b0; req_down = 1'b0; req_left = 1'b0; req_right = 1'b0;
    endtask

    // DUT is in its ISSUE cycle: advance the model and compare.
    task automatic expect_issue(input int k, input logic [15:0] opnd);
        case (k)
            0: begin mx = SPX; my = SPY; mshape = int'(opnd[1:0]); end
            2: my = my - 1;
            3: mx = mx - 1;
            4: mx = mx + 1;
            default: mx = mx;
        endcase
        chk("issue_op", instr_op, op_of(k));
        chk("issue_busy", busy, 1);
        chk("issue_x", x_pos, mx);
        chk("issue_y", y_pos, my);
        chk("issue_shape", shape, mshape);
        if (k == 1) chk("issue_rm_line", rm_line_num, opnd);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("done_latency", lat, exp_lat);
        chk("done_busy", busy, 0);
        chk("done_gln", get_line_num, 5'h1F);
    endtask

    task automatic wait_issue(input int k, input logic [15:0] opnd);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_op !== 6'h00 && instr_op !== 6'h1F) begin
                found = 1'b1;
                break;
            end
        end
        chk("issue_seen", found, 1);
        expect_issue(k, opnd);
    endtask

    // One isolated request from an idle DUT with nothing pending.
    task automatic txn(input int k, input logic [15:0] opnd);
        pulse(k, opnd);
        if (!legal(k)) begin
            tick();
            chk("rej_pulse", reject, 1);
            chk("rej_busy", busy, 0);
            chk("rej_op", instr_op, 0);
            chk("rej_x", x_pos, mx);
            chk("rej_y", y_pos, my);
            tick();
            chk("rej_once", reject, 0);
            chk("rej_idle", busy, 0);
        end else begin
            tick();
            expect_issue(k, opnd);
            wait_done(LAT);
            tick();
            tick();
            chk("idle_after", busy, 0);
        end
    endtask

    initial begin
        int k;
        logic [15:0] opnd;
        bit found;

        rst_n = 1'b0;
        req_new = 1'b0; req_rm = 1'b0; req_down = 1'b0; req_left = 1'b0; req_right = 1'b0;
        shape_sel = 2'b00; rm_sel = 16'h0000; line_status = 32'h0000_0000;
        tick();
        tick();
        chk("rst_op", instr_op, 0);
        chk("rst_rm", rm_line_num, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_shape", shape, 0);
        chk("rst_gln", get_line_num, 5'h1F);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reject", reject, 0);
        rst_n = 1'b1;
        tick();

        // Left at x=0 and down at y=0 are rejected
        txn(3, 16'h0);
        txn(2, 16'h0);

        // Spawn a line piece with a full scan
        pulse(0, 16'h0001);
        tick();
        expect_issue(0, 16'h0001);
        for (int r = 0; r < ROWS; r++) begin
            for (int h = 0; h < HOLD; h++) begin
                tick();
                chk("scan_row", get_line_num, r);
                chk("scan_op", instr_op, 6'h1F);
            end
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy0", busy, 0);
        chk("done_gln1f", get_line_num, 5'h1F);
        tick();
        chk("done_once", done, 0);

        // Requests while busy: priority order and coalescing
        pulse(0, 16'h0000);
        tick();
        expect_issue(0, 16'h0000);
        req_right = 1'b1; req_down = 1'b1; req_left = 1'b1;
        tick();
        req_right = 1'b0; req_down = 1'b0; req_left = 1'b0;
        tick();
        pulse(2, 16'h0);
        wait_done(LAT - 3);
        wait_issue(2, 16'h0);
        wait_done(LAT);
        wait_issue(3, 16'h0);
        wait_done(LAT);
        wait_issue(4, 16'h0);
        wait_done(LAT);
        tick();
        tick();
        tick();
        chk("coalesced", busy, 0);

        // Sixteen drops from spawn height reach y=0, the next is rejected
        txn(0, 16'h0);
        for (int i = 0; i < SPY; i++) txn(2, 16'h0);
        chk("floor_y", y_pos, 0);
        txn(2, 16'h0);

        // Right edge
        for (int i = SPX; i < XMAX; i++) txn(4, 16'h0);
        chk("edge_x", x_pos, XMAX);
        txn(4, 16'h0);

        // Randomized single requests
        for (int i = 0; i < 25; i++) begin
            k = int'($urandom_range(0, 4));
            opnd = 16'($urandom);
            if (k == 0) opnd = {15'd0, opnd[0]};
`ifndef GB_SEQ_AUTO_CLEAR_EN
            line_status = $urandom;
`endif
            txn(k, opnd);
        end
        line_status = 32'h0000_0000;

`ifdef GB_SEQ_AUTO_CLEAR_EN
        // Full row after a drop queues REMOVE ahead of a pending left
        txn(0, 16'h0);
        pulse(2, 16'h0);
        tick();
        expect_issue(2, 16'h0);
        tick();
        line_status = 32'h0000_0004;
        pulse(3, 16'h0);
        wait_done(LAT - 2);
        wait_issue(1, 16'h0002);
        line_status = 32'h0000_0000;
        wait_done(LAT);
        wait_issue(3, 16'h0);
        wait_done(LAT);
`endif

        // Asynchronous reset in the middle of a scan drops queued work
        pulse(0, 16'h0001);
        tick();
        expect_issue(0, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (get_line_num === 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("row7_seen", found, 1);
        pulse(3, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_op", instr_op, 0);
        chk("arst_gln", get_line_num, 5'h1F);
        chk("arst_x", x_pos, 0);
        tick();
        chk("arst_busy_held", busy, 0);
        rst_n = 1'b1;
        mx = 0; my = 0; mshape = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_reject", reject, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
